// File: rtl/traffic_pkg.sv
// Shared types for the two-road traffic phase scheduler.
// Holds the phase encoding, the timer width and the lamp decode.
package traffic_pkg;

    localparam int TIMER_W = 8;

    typedef enum logic [2:0] {
        PH_G1   = 3'd0,
        PH_Y1   = 3'd1,
        PH_AR1  = 3'd2,
        PH_G2   = 3'd3,
        PH_Y2   = 3'd4,
        PH_AR2  = 3'd5,
        PH_WALK = 3'd6
    } phase_t;

    typedef struct packed {
        logic r1;
        logic y1;
        logic g1;
        logic r2;
        logic y2;
        logic g2;
        logic walk;
    } lamps_t;

    // Exactly one lamp per road is lit in every phase; unknown codes fall back to all-red.
    function automatic lamps_t decode_lamps(input phase_t ph);
        lamps_t l;
        l = '0;
        case (ph)
            PH_G1: begin
                l.g1 = 1'b1;
                l.r2 = 1'b1;
            end
            PH_Y1: begin
                l.y1 = 1'b1;
                l.r2 = 1'b1;
            end
            PH_G2: begin
                l.r1 = 1'b1;
                l.g2 = 1'b1;
            end
            PH_Y2: begin
                l.r1 = 1'b1;
                l.y2 = 1'b1;
            end
            PH_WALK: begin
                l.r1   = 1'b1;
                l.r2   = 1'b1;
                l.walk = 1'b1;
            end
            default: begin
                l.r1 = 1'b1;
                l.r2 = 1'b1;
            end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_phase_timer.sv
// Saturating up-counter measuring time spent in the current phase.
// A synchronous clear restarts it at zero on every phase entry.
module phase_timer
    import traffic_pkg::*;
(
    input  logic               clk,
    input  logic               srst,
    input  logic               clear,
    output logic [TIMER_W-1:0] count
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_q != '1) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven phase sequencer for a two-road intersection with a pedestrian walk.
// Holds the phase FSM, pending walk request, post-walk road selector and registered lamps.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN = 10,
    parameter int GREEN_MAX = 30,
    parameter int YELLOW    = 3,
    parameter int ALL_RED   = 1,
    parameter int WALK      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       car1,
    input  logic       car2,
    input  logic       ped_req,
    output logic       r1,
    output logic       y1,
    output logic       g1,
    output logic       r2,
    output logic       y2,
    output logic       g2,
    output logic       walk,
    output logic [2:0] phase
);

    // Thresholds are "duration - 1" because the timer reads 0 in the first cycle of a phase.
    localparam logic [TIMER_W-1:0] GMIN_LAST  = TIMER_W'(GREEN_MIN - 1);
    localparam logic [TIMER_W-1:0] GMAX_LAST  = TIMER_W'(GREEN_MAX - 1);
    localparam logic [TIMER_W-1:0] YEL_LAST   = TIMER_W'(YELLOW - 1);
    localparam logic [TIMER_W-1:0] AR_LAST    = TIMER_W'(ALL_RED - 1);
    localparam logic [TIMER_W-1:0] WALK_LAST  = TIMER_W'(WALK - 1);

    localparam logic ROAD1 = 1'b0;
    localparam logic ROAD2 = 1'b1;

    phase_t             state_q;
    phase_t             state_d;
    logic               ped_pending_q;
    logic               ped_pending_d;
    logic               next_road_q;
    logic               next_road_d;
    lamps_t             lamps_q;
    lamps_t             lamps_d;
    logic [TIMER_W-1:0] timer;
    logic               timer_clear;
    logic               g1_done;
    logic               g2_done;

    phase_timer u_phase_timer (
        .clk   (clk),
        .srst  (reset),
        .clear (timer_clear),
        .count (timer)
    );

    assign g1_done = (car2 | ped_pending_q) &&
                     (((timer >= GMIN_LAST) && !car1) || (timer >= GMAX_LAST));
    assign g2_done = (car1 | ped_pending_q) &&
                     (((timer >= GMIN_LAST) && !car2) || (timer >= GMAX_LAST));

    assign timer_clear = (state_d != state_q);

    always_comb begin
        state_d       = state_q;
        next_road_d   = next_road_q;
        ped_pending_d = ped_pending_q;
        case (state_q)
            PH_G1: begin
                if (g1_done) state_d = PH_Y1;
            end
            PH_Y1: begin
                if (timer == YEL_LAST) state_d = PH_AR1;
            end
            PH_AR1: begin
                if (timer == AR_LAST) begin
                    next_road_d = ROAD2;
                    state_d     = ped_pending_q ? PH_WALK : PH_G2;
                end
            end
            PH_G2: begin
                if (g2_done) state_d = PH_Y2;
            end
            PH_Y2: begin
                if (timer == YEL_LAST) state_d = PH_AR2;
            end
            PH_AR2: begin
                if (timer == AR_LAST) begin
                    next_road_d = ROAD1;
                    state_d     = ped_pending_q ? PH_WALK : PH_G1;
                end
            end
            PH_WALK: begin
                if (timer == WALK_LAST) begin
                    state_d = (next_road_q == ROAD2) ? PH_G2 : PH_G1;
                end
            end
            default: state_d = PH_G1;
        endcase

        // Entering WALK wins over a press in the same cycle, so that press is dropped.
        if ((state_d == PH_WALK) && (state_q != PH_WALK)) begin
            ped_pending_d = 1'b0;
        end else if (ped_req && (state_q != PH_WALK)) begin
            ped_pending_d = 1'b1;
        end

        lamps_d = decode_lamps(state_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= PH_G1;
            ped_pending_q <= 1'b0;
            next_road_q   <= ROAD1;
            lamps_q       <= decode_lamps(PH_G1);
        end else begin
            state_q       <= state_d;
            ped_pending_q <= ped_pending_d;
            next_road_q   <= next_road_d;
            lamps_q       <= lamps_d;
        end
    end

    assign r1    = lamps_q.r1;
    assign y1    = lamps_q.y1;
    assign g1    = lamps_q.g1;
    assign r2    = lamps_q.r2;
    assign y2    = lamps_q.y2;
    assign g2    = lamps_q.g2;
    assign walk  = lamps_q.walk;
    assign phase = state_q;

endmodule
